// File: rtl/quick_rs232.sv
// quick_rs232: full-duplex RS-232 UART with RX FIFO and optional RTS/CTS.
// Fixed frame format, baud rate and FIFO depth set by parameters.
module quick_rs232 #(
    parameter int CLK_FREQ                = 50000000,
    parameter int DEFAULT_BYTE_LEN        = 8,
    parameter int DEFAULT_PARITY          = 1,
    parameter int DEFAULT_STOP_BITS       = 0,
    parameter int DEFAULT_BAUD_RATE       = 115200,
    parameter int DEFAULT_RECV_BUFFER_LEN = 16,
    parameter int DEFAULT_FLOW_CONTROL    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic       rts,
    output logic       cts,
    input  logic       rx_read,
    output logic       rx_err,
    output logic [7:0] rx_data,
    output logic       rx_byte_received,
    input  logic       tx_transaction,
    input  logic [7:0] tx_data,
    input  logic       tx_data_ready,
    output logic       tx_data_copied,
    output logic       tx_busy
);
    localparam int BIT_CLKS = CLK_FREQ / DEFAULT_BAUD_RATE;
    localparam int CW       = $clog2(BIT_CLKS + 1);
    localparam int BL       = DEFAULT_BYTE_LEN;
    localparam int DEPTH    = DEFAULT_RECV_BUFFER_LEN;
    localparam int AW       = $clog2(DEPTH);
    localparam bit PAR_EN   = (DEFAULT_PARITY != 0);
    localparam bit PAR_ODD  = (DEFAULT_PARITY == 2);

    localparam logic [CW-1:0] LP_LAST    = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] LP_HALF    = CW'(BIT_CLKS / 2 - 1);
    localparam logic [2:0]    LP_IDX_END = 3'(BL - 1);
    localparam logic [AW:0]   LP_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LP_CTS_MAX = (AW+1)'(DEPTH - 2);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
    } tx_state_t;

    // ---------------- receive path ----------------
    logic          r_rx_s1, r_rx_s2, r_rx_s3;
    rx_state_t     r_rx_state;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_idx;
    logic [BL-1:0] r_rx_shift;
    logic          r_rx_par;
    logic          r_rx_err;
    logic          r_rx_rcv;
    logic [7:0]    r_rx_data;
    logic [BL-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_cts;

    logic w_rx, w_fall, w_pop, w_full, w_stop_smp, w_par_ok, w_good, w_push;

    assign w_rx       = r_rx_s2;
    assign w_fall     = r_rx_s3 & ~r_rx_s2;
    assign w_pop      = rx_read & (r_count != '0);
    assign w_full     = (r_count == LP_DEPTH);
    assign w_stop_smp = (r_rx_state == RX_STOP) && (r_rx_cnt == LP_LAST);
    assign w_par_ok   = !PAR_EN || (r_rx_par == ((^r_rx_shift) ^ PAR_ODD));
    assign w_good     = w_stop_smp & w_rx & w_par_ok;
    // A simultaneous pop frees the slot, so a full FIFO still accepts
    assign w_push     = w_good & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
            r_rx_err   <= 1'b0;
            r_rx_rcv   <= 1'b0;
            r_rx_data  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_cts      <= 1'b0;
        end else begin
            r_rx_s1  <= rx;
            r_rx_s2  <= r_rx_s1;
            r_rx_s3  <= r_rx_s2;
            r_rx_err <= w_stop_smp & ~w_push;
            r_rx_rcv <= w_push;
            unique case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= '0;
                    if (w_fall) r_rx_state <= RX_START;
                end
                RX_START: begin
                    if (r_rx_cnt == LP_HALF) begin
                        r_rx_cnt   <= '0;
                        r_rx_idx   <= '0;
                        r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == LP_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {w_rx, r_rx_shift[BL-1:1]};
                        r_rx_idx   <= r_rx_idx + 1'b1;
                        if (r_rx_idx == LP_IDX_END)
                            r_rx_state <= PAR_EN ? RX_PAR : RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_PAR: begin
                    if (r_rx_cnt == LP_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_par   <= w_rx;
                        r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == LP_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rx_data <= 8'(r_mem[r_rd_ptr]);
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (DEFAULT_FLOW_CONTROL == 0) r_cts <= 1'b1;
            else r_cts <= rts && (r_count <= LP_CTS_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_rx_shift;
    end

    // ---------------- transmit path ----------------
    tx_state_t     r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_idx;
    logic [BL-1:0] r_tx_shift;
    logic          r_tx_par;
    logic          r_tx_stop;
    logic          r_tx;
    logic          r_tx_copied;
    logic          r_tx_busy;
    logic          w_launch;

    assign w_launch = tx_transaction & tx_data_ready
                    & ((DEFAULT_FLOW_CONTROL == 0) | rts);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state  <= TX_IDLE;
            r_tx_cnt    <= '0;
            r_tx_idx    <= '0;
            r_tx_shift  <= '0;
            r_tx_par    <= 1'b0;
            r_tx_stop   <= 1'b0;
            r_tx        <= 1'b1;
            r_tx_copied <= 1'b0;
            r_tx_busy   <= 1'b0;
        end else begin
            r_tx_copied <= 1'b0;
            if (r_tx_state != TX_IDLE) begin
                r_tx_cnt <= (r_tx_cnt == LP_LAST) ? '0 : r_tx_cnt + 1'b1;
            end
            unique case (r_tx_state)
                TX_IDLE: begin
                    r_tx     <= 1'b1;
                    r_tx_cnt <= '0;
                    if (w_launch) begin
                        r_tx_shift  <= tx_data[BL-1:0];
                        r_tx_par    <= (^tx_data[BL-1:0]) ^ PAR_ODD;
                        r_tx_copied <= 1'b1;
                        r_tx_busy   <= 1'b1;
                        r_tx        <= 1'b0;
                        r_tx_state  <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == LP_LAST) begin
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_idx   <= '0;
                        r_tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == LP_LAST) begin
                        if (r_tx_idx == LP_IDX_END) begin
                            r_tx_stop  <= 1'b0;
                            r_tx       <= PAR_EN ? r_tx_par : 1'b1;
                            r_tx_state <= PAR_EN ? TX_PAR : TX_STOP;
                        end else begin
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_idx   <= r_tx_idx + 1'b1;
                        end
                    end
                end
                TX_PAR: begin
                    if (r_tx_cnt == LP_LAST) begin
                        r_tx       <= 1'b1;
                        r_tx_state <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (r_tx_cnt == LP_LAST) begin
                        if ((DEFAULT_STOP_BITS != 0) && !r_tx_stop) begin
                            r_tx_stop <= 1'b1;
                        end else begin
                            r_tx_busy  <= 1'b0;
                            r_tx_state <= TX_IDLE;
                        end
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign tx               = r_tx;
    assign cts              = r_cts;
    assign rx_err           = r_rx_err;
    assign rx_data          = r_rx_data;
    assign rx_byte_received = r_rx_rcv;
    assign tx_data_copied   = r_tx_copied;
    assign tx_busy          = r_tx_busy;
endmodule

// File: tb/tb_quick_rs232.sv
// Bench for quick_rs232: a default instance for frame timing and a
// fast RTS/CTS instance for FIFO depth and flow-control behaviour.
module tb_quick_rs232;
    localparam int BC_A = 50000000 / 115200;
    localparam int BC_B = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    logic       rx_a = 1'b1, rts_a = 1'b0, rx_read_a = 1'b0;
    logic       tx_transaction_a = 1'b0, tx_data_ready_a = 1'b0;
    logic [7:0] tx_data_a = '0;
    logic       tx_a, cts_a, rx_err_a, rx_byte_received_a;
    logic       tx_data_copied_a, tx_busy_a;
    logic [7:0] rx_data_a;

    logic       rx_b = 1'b1, rts_b = 1'b0, rx_read_b = 1'b0;
    logic       tx_transaction_b = 1'b0, tx_data_ready_b = 1'b0;
    logic [7:0] tx_data_b = '0;
    logic       tx_b, cts_b, rx_err_b, rx_byte_received_b;
    logic       tx_data_copied_b, tx_busy_b;
    logic [7:0] rx_data_b;

    quick_rs232 u_a (
        .clk(clk), .rst(rst), .rx(rx_a), .tx(tx_a),
        .rts(rts_a), .cts(cts_a), .rx_read(rx_read_a),
        .rx_err(rx_err_a), .rx_data(rx_data_a),
        .rx_byte_received(rx_byte_received_a),
        .tx_transaction(tx_transaction_a), .tx_data(tx_data_a),
        .tx_data_ready(tx_data_ready_a),
        .tx_data_copied(tx_data_copied_a), .tx_busy(tx_busy_a)
    );

    quick_rs232 #(
        .DEFAULT_BAUD_RATE(5000000),
        .DEFAULT_FLOW_CONTROL(1)
    ) u_b (
        .clk(clk), .rst(rst), .rx(rx_b), .tx(tx_b),
        .rts(rts_b), .cts(cts_b), .rx_read(rx_read_b),
        .rx_err(rx_err_b), .rx_data(rx_data_b),
        .rx_byte_received(rx_byte_received_b),
        .tx_transaction(tx_transaction_b), .tx_data(tx_data_b),
        .tx_data_ready(tx_data_ready_b),
        .tx_data_copied(tx_data_copied_b), .tx_busy(tx_busy_b)
    );

    int n_checks = 0;
    int n_err    = 0;
    int n_rcv_a = 0, n_err_a = 0, n_cp_a = 0;
    int n_rcv_b = 0, n_err_b = 0, n_cp_b = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic       txq[$];

    always @(negedge clk) begin
        if (rx_byte_received_a) n_rcv_a++;
        if (rx_err_a)           n_err_a++;
        if (tx_data_copied_a)   n_cp_a++;
        if (rx_byte_received_b) n_rcv_b++;
        if (rx_err_b)           n_err_b++;
        if (tx_data_copied_b)   n_cp_b++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Even parity, 8 data bits, one stop bit; optional corruptions
    task automatic send_frame(input bit sel, input logic [7:0] d,
                              input bit bad_par, input bit bad_stop,
                              input int bc);
        logic [10:0] f;
        f = {~bad_stop, (^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (sel) rx_b = f[i];
            else     rx_a = f[i];
            repeat (bc) @(negedge clk);
        end
        if (sel) rx_b = 1'b1;
        else     rx_a = 1'b1;
        repeat (2 * bc) @(negedge clk);
    endtask

    task automatic read_a();
        @(negedge clk) rx_read_a = 1'b1;
        @(negedge clk) rx_read_a = 1'b0;
    endtask

    task automatic read_b();
        @(negedge clk) rx_read_b = 1'b1;
        @(negedge clk) rx_read_b = 1'b0;
    endtask

    initial begin
        logic       found;
        logic       cur;
        logic [7:0] d;
        logic [7:0] last;
        int         mism;
        int         blen;

        cur = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        check("reset_a", {18'd0, tx_a, cts_a, rx_err_a, rx_byte_received_a,
              tx_data_copied_a, tx_busy_a, rx_data_a}, {18'd0, 6'b100000, 8'h00});
        check("reset_b", {18'd0, tx_b, cts_b, rx_err_b, rx_byte_received_b,
              tx_data_copied_b, tx_busy_b, rx_data_b}, {18'd0, 6'b100000, 8'h00});
        @(negedge clk);
        check("cts_a_after_reset", cts_a, 1);
        check("cts_b_rts_low", cts_b, 0);

        // TX 0xA5 on the default instance
        txq.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            d = 8'hA5;
            txq.push_back(d[i]);
        end
        txq.push_back(1'b0);
        txq.push_back(1'b1);
        tx_data_a = 8'hA5;
        tx_transaction_a = 1'b1;
        tx_data_ready_a = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (tx_data_copied_a) begin
                found = 1'b1;
                break;
            end
        end
        check("tx_launch_a", found, 1);
        check("tx_start_state", {tx_a, tx_busy_a}, 2'b01);
        tx_data_ready_a = 1'b0;
        mism = 0;
        blen = 0;
        for (int c = 0; c < 11 * BC_A; c++) begin
            if (c % BC_A == 0) cur = txq.pop_front();
            if (tx_a !== cur) mism++;
            if (tx_busy_a) blen++;
            @(posedge clk); #1;
        end
        check("tx_wave_mismatches", mism, 0);
        check("tx_busy_len", blen, 11 * BC_A);
        check("tx_end_idle", {tx_a, tx_busy_a}, 2'b10);
        repeat (20) @(negedge clk);
        check("tx_copied_count", n_cp_a, 1);

        // RX on the default instance
        q_a.push_back(8'h3C);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, BC_A);
        check("rx_rcv_count", n_rcv_a, 1);
        check("rx_err_none", n_err_a, 0);
        read_a();
        check("rx_data_3c", rx_data_a, q_a.pop_front());
        send_frame(1'b0, 8'h55, 1'b1, 1'b0, BC_A);
        check("rx_err_parity", n_err_a, 1);
        send_frame(1'b0, 8'hC3, 1'b0, 1'b1, BC_A);
        check("rx_err_framing", n_err_a, 2);
        check("rx_rcv_unchanged", n_rcv_a, 1);
        read_a();
        check("rx_empty_read_holds", rx_data_a, 8'h3C);

        // Flow control on the fast instance
        tx_data_b = 8'h5A;
        tx_transaction_b = 1'b1;
        tx_data_ready_b = 1'b1;
        repeat (40) @(negedge clk);
        check("fc_no_launch", {n_cp_b[7:0], 7'd0, tx_busy_b}, 16'h0000);
        check("fc_cts_low", cts_b, 0);
        rts_b = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_data_copied_b) begin
                found = 1'b1;
                break;
            end
        end
        check("fc_launch", found, 1);
        tx_data_ready_b = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!tx_busy_b) begin
                found = 1'b1;
                break;
            end
        end
        check("fc_tx_done", found, 1);
        check("fc_copied_count", n_cp_b, 1);
        check("fc_cts_high", cts_b, 1);

        // Fill 16-deep FIFO and overrun it
        for (int i = 0; i < 17; i++) begin
            d = 8'(8'h20 + i * 7);
            if (i < 16) q_b.push_back(d);
            send_frame(1'b1, d, 1'b0, 1'b0, BC_B);
            if (i == 13) check("cts_at_14", cts_b, 1);
            if (i == 14) check("cts_at_15", cts_b, 0);
        end
        check("fifo_rcv_count", n_rcv_b, 16);
        check("fifo_overrun_err", n_err_b, 1);
        check("fifo_full_cts", cts_b, 0);
        last = '0;
        for (int i = 0; i < 16; i++) begin
            read_b();
            last = q_b.pop_front();
            check("fifo_order", rx_data_b, last);
        end
        read_b();
        check("fifo_empty_read", rx_data_b, last);
        check("fifo_drained_cts", cts_b, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
